// File: rtl/tomasulo_issue_ctrl_if.sv
// Interface bundling the queue, issue, CDB and statistics signals of the Tomasulo issue
// stage. The controller connects through the slave modport; the instruction queue, the
// reservation stations and the CDB together act as the master.
//   Queue   : iq_valid, opcode, rx, ry, rz, immediate (to ctrl), stall (from ctrl)
//   Control : flush (to ctrl)
//   CDB     : cdb_valid, cdb_tag (to ctrl)
//   RS write: issue_valid, issue_tag, issue_op, issue_qj, issue_qk, issue_rj, issue_rk,
//             issue_imm (from ctrl)
//   Status  : illegal_op, stat_issued, stat_stalls (from ctrl)
interface tomasulo_issue_ctrl_if #(
   parameter int unsigned TAG_W = 3
);
   logic             iq_valid;
   logic [2:0]       opcode;
   logic [2:0]       rx;
   logic [2:0]       ry;
   logic [2:0]       rz;
   logic [3:0]       immediate;
   logic             flush;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic             stall;
   logic             issue_valid;
   logic [TAG_W-1:0] issue_tag;
   logic [2:0]       issue_op;
   logic [TAG_W-1:0] issue_qj;
   logic [TAG_W-1:0] issue_qk;
   logic [2:0]       issue_rj;
   logic [2:0]       issue_rk;
   logic [3:0]       issue_imm;
   logic             illegal_op;
   logic [15:0]      stat_issued;
   logic [15:0]      stat_stalls;

   modport master (
      output iq_valid, opcode, rx, ry, rz, immediate, flush, cdb_valid, cdb_tag,
      input  stall, issue_valid, issue_tag, issue_op, issue_qj, issue_qk, issue_rj, issue_rk,
             issue_imm, illegal_op, stat_issued, stat_stalls
   );

   modport slave (
      input  iq_valid, opcode, rx, ry, rz, immediate, flush, cdb_valid, cdb_tag,
      output stall, issue_valid, issue_tag, issue_op, issue_qj, issue_qk, issue_rj, issue_rk,
             issue_imm, illegal_op, stat_issued, stat_stalls
   );
endinterface

// File: rtl/tomasulo_issue_ctrl.sv
// Issue stage of a Tomasulo pipeline, between the instruction queue and the reservation
// stations. Classifies the queued instruction, allocates the lowest free RS entry of its
// class (A-pool tags 1..NUM_ARS for ADD/SUB, L-pool tags NUM_ARS+1.. for LD/SD), renames
// the destination in the register status table (Qi), returns source tags and drives the
// queue stall. CDB broadcasts free entries and clear matching Qi.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    tomasulo_issue_ctrl_if.slave (queue, flush, CDB, RS write, status)
// Optional feature: define TOMASULO_ISSUE_STATS_EN to build the saturating 16-bit
// stat_issued / stat_stalls counters; otherwise both read 0 and no counters exist.
module tomasulo_issue_ctrl #(
   parameter int unsigned NUM_ARS  = 3,
   parameter int unsigned NUM_LRS  = 2,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned TAG_W    = 3
) (
   input logic                  clock,
   input logic                  reset,
   tomasulo_issue_ctrl_if.slave bus
);
   localparam logic [2:0] OpLd = 3'b010;
   localparam logic [2:0] OpSd = 3'b011;

   typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

   state_e             state_q;
   logic               blocked_l_q;
   logic [NUM_ARS-1:0] busy_a_q;
   logic [NUM_LRS-1:0] busy_l_q;
   logic [TAG_W-1:0]   qi_q [NUM_REGS];

   logic               issue_valid_q;
   logic               illegal_q;
   logic [TAG_W-1:0]   issue_tag_q;
   logic [2:0]         issue_op_q;
   logic [TAG_W-1:0]   issue_qj_q;
   logic [TAG_W-1:0]   issue_qk_q;
   logic [2:0]         issue_rj_q;
   logic [2:0]         issue_rk_q;
   logic [3:0]         issue_imm_q;

   logic               legal, use_l, pool_full, stall, fire, drop, blocked_free;
   logic [TAG_W-1:0]   alloc_tag, qj_raw, qk_raw, qj, qk;
   logic [2:0]         rk_src, rk;
   logic [NUM_ARS-1:0] cdb_clr_a, alloc_a;
   logic [NUM_LRS-1:0] cdb_clr_l, alloc_l;

   always_comb begin
      legal     = ~bus.opcode[2];
      use_l     = bus.opcode[1];
      pool_full = use_l ? (&busy_l_q) : (&busy_a_q);
      stall     = (state_q == StFlush) || (state_q == StStall) ||
                  ((state_q == StRun) && bus.iq_valid && legal && pool_full);
      fire      = (state_q == StRun) && bus.iq_valid && legal && !pool_full && !bus.flush;
      drop      = (state_q == StRun) && bus.iq_valid && !legal && !bus.flush;

      // Lowest free entry wins: scan high to low so the last hit is the smallest index.
      alloc_tag = '0;
      for (int i = int'(NUM_ARS) - 1; i >= 0; i--) begin
         if (!use_l && !busy_a_q[i]) alloc_tag = TAG_W'(i + 1);
      end
      for (int i = int'(NUM_LRS) - 1; i >= 0; i--) begin
         if (use_l && !busy_l_q[i]) alloc_tag = TAG_W'(int'(NUM_ARS) + 1 + i);
      end

      for (int i = 0; i < int'(NUM_ARS); i++) begin
         cdb_clr_a[i] = bus.cdb_valid && (bus.cdb_tag == TAG_W'(i + 1));
         alloc_a[i]   = fire && !use_l && (alloc_tag == TAG_W'(i + 1));
      end
      for (int i = 0; i < int'(NUM_LRS); i++) begin
         cdb_clr_l[i] = bus.cdb_valid && (bus.cdb_tag == TAG_W'(int'(NUM_ARS) + 1 + i));
         alloc_l[i]   = fire && use_l && (alloc_tag == TAG_W'(int'(NUM_ARS) + 1 + i));
      end

      // Source lookup bypasses a producer that completes on the CDB this very cycle.
      qj_raw = qi_q[bus.ry];
      qj     = (bus.cdb_valid && (qj_raw == bus.cdb_tag)) ? '0 : qj_raw;
      rk_src = (bus.opcode == OpSd) ? bus.rx : bus.rz;
      qk_raw = qi_q[rk_src];
      qk     = (bus.cdb_valid && (qk_raw == bus.cdb_tag)) ? '0 : qk_raw;
      rk     = rk_src;
      if (bus.opcode == OpLd) begin
         qk = '0;
         rk = '0;
      end

      // Leave STALL once the blocked pool has a free entry; also covers a CDB that freed
      // the entry on the very edge that entered STALL.
      blocked_free = blocked_l_q ? (!(&busy_l_q) || (|cdb_clr_l))
                                 : (!(&busy_a_q) || (|cdb_clr_a));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= StRun;
         blocked_l_q   <= 1'b0;
         busy_a_q      <= '0;
         busy_l_q      <= '0;
         for (int r = 0; r < int'(NUM_REGS); r++) qi_q[r] <= '0;
         issue_valid_q <= 1'b0;
         illegal_q     <= 1'b0;
         issue_tag_q   <= '0;
         issue_op_q    <= '0;
         issue_qj_q    <= '0;
         issue_qk_q    <= '0;
         issue_rj_q    <= '0;
         issue_rk_q    <= '0;
         issue_imm_q   <= '0;
      end else begin
         issue_valid_q <= fire;
         illegal_q     <= drop;
         if (fire) begin
            issue_tag_q <= alloc_tag;
            issue_op_q  <= bus.opcode;
            issue_qj_q  <= qj;
            issue_qk_q  <= qk;
            issue_rj_q  <= bus.ry;
            issue_rk_q  <= rk;
            issue_imm_q <= bus.immediate;
         end
         if (bus.flush) begin
            state_q  <= StFlush;
            busy_a_q <= '0;
            busy_l_q <= '0;
            for (int r = 0; r < int'(NUM_REGS); r++) qi_q[r] <= '0;
         end else begin
            busy_a_q <= (busy_a_q & ~cdb_clr_a) | alloc_a;
            busy_l_q <= (busy_l_q & ~cdb_clr_l) | alloc_l;
            for (int r = 0; r < int'(NUM_REGS); r++) begin
               if (bus.cdb_valid && (bus.cdb_tag != '0) && (qi_q[r] == bus.cdb_tag)) begin
                  qi_q[r] <= '0;
               end
            end
            // Placed after the CDB clear so a rename of the same register wins.
            if (fire && (bus.opcode != OpSd)) qi_q[bus.rx] <= alloc_tag;
            unique case (state_q)
               StRun: begin
                  if (bus.iq_valid && legal && pool_full) begin
                     state_q     <= StStall;
                     blocked_l_q <= use_l;
                  end
               end
               StStall: if (blocked_free) state_q <= StRun;
               StFlush: state_q <= StRun;
               default: state_q <= StRun;
            endcase
         end
      end
   end

   assign bus.stall       = stall;
   assign bus.issue_valid = issue_valid_q;
   assign bus.issue_tag   = issue_tag_q;
   assign bus.issue_op    = issue_op_q;
   assign bus.issue_qj    = issue_qj_q;
   assign bus.issue_qk    = issue_qk_q;
   assign bus.issue_rj    = issue_rj_q;
   assign bus.issue_rk    = issue_rk_q;
   assign bus.issue_imm   = issue_imm_q;
   assign bus.illegal_op  = illegal_q;

`ifdef TOMASULO_ISSUE_STATS_EN
   logic [15:0] stat_issued_q, stat_stalls_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_issued_q <= '0;
         stat_stalls_q <= '0;
      end else begin
         if (fire && (stat_issued_q != 16'hFFFF)) stat_issued_q <= stat_issued_q + 16'd1;
         if (stall && (stat_stalls_q != 16'hFFFF)) stat_stalls_q <= stat_stalls_q + 16'd1;
      end
   end

   assign bus.stat_issued = stat_issued_q;
   assign bus.stat_stalls = stat_stalls_q;
`else
   assign bus.stat_issued = '0;
   assign bus.stat_stalls = '0;
`endif
endmodule
